// File: rtl/mm_cdr_loop_filter_mc_if.sv
`default_nettype none
// ============================================================================
// mm_cdr_loop_filter_mc_if
// Phase-error sample stream plus 4-phase debug snapshot port of the CDR filter.
// Revision: 1.0
// ============================================================================
interface mm_cdr_loop_filter_mc_if #(
  parameter int PE_W  = 8,
  parameter int ACC_W = 15
);
  logic signed [PE_W-1:0]  pe_in;
  logic                    pe_valid;
  logic                    snap_req;
  logic                    snap_ack;
  logic [ACC_W-1:0]        snap_phase;
  logic signed [ACC_W-1:0] snap_freq;

  modport master (
    output pe_in, pe_valid, snap_req,
    input  snap_ack, snap_phase, snap_freq
  );

  modport slave (
    input  pe_in, pe_valid, snap_req,
    output snap_ack, snap_phase, snap_freq
  );
endinterface
`default_nettype wire

// File: rtl/mm_cdr_loop_filter_mc.sv
`default_nettype none
// ============================================================================
// mm_cdr_loop_filter_mc
// PI loop filter for an MM-detector CDR driving NOUT phase-interpolator lanes.
// Revision: 1.0
// ============================================================================
module mm_cdr_loop_filter_mc #(
  parameter int PE_W   = 8,
  parameter int NPI    = 9,
  parameter int NOUT   = 4,
  parameter int FRAC   = 6,
  parameter int KP_W   = 4,
  parameter int KI_W   = 4,
  parameter int LOCK_W = 10
) (
  input  logic                      clk,
  input  logic                      ext_rstb,
  mm_cdr_loop_filter_mc_if.slave    lf_if,
  input  logic [KP_W-1:0]           kp_i,
  input  logic [KI_W-1:0]           ki_i,
  input  logic                      en_freq_i,
  input  logic                      freeze_i,
  input  logic                      en_ext_i,
  input  logic [NPI-1:0]            pi_ext_i,
  input  logic [NOUT-1:0][NPI-1:0]  pi_offset_i,
  input  logic [PE_W-2:0]           lock_thresh_i,
  input  logic [LOCK_W-1:0]         lock_len_i,
  output logic [NOUT-1:0][NPI-1:0]  pi_ctl_o,
  output logic                      locked_o
);

  localparam int ACC_W = NPI + FRAC;
  localparam int SMAX  = ACC_W - PE_W;
  localparam logic [KP_W-1:0]  KP_MAX = KP_W'(SMAX);
  localparam logic [KI_W-1:0]  KI_MAX = KI_W'(SMAX);
  localparam logic [ACC_W-1:0] F_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] F_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } snap_state_e;

  logic [ACC_W-1:0]         phase_q, phase_d;
  logic [ACC_W-1:0]         freq_q, freq_d;
  logic [LOCK_W-1:0]        cnt_q, cnt_d;
  logic                     locked_q, locked_d;
  logic [NOUT-1:0][NPI-1:0] pi_ctl_q;
  logic [NPI-1:0]           pi_lane_d [NOUT];
  logic [ACC_W-1:0]         snap_phase_q, snap_phase_d;
  logic [ACC_W-1:0]         snap_freq_q, snap_freq_d;
  snap_state_e              state_q, state_d;
  logic                     snap_ack;
  logic                     capture_en;

  logic                     upd;
  logic [KP_W-1:0]          kp_c;
  logic [KI_W-1:0]          ki_c;
  logic [ACC_W-1:0]         pe_sx;
  logic [ACC_W-1:0]         p_term;
  logic [ACC_W-1:0]         i_term;
  logic [ACC_W:0]           f_sum;
  logic [ACC_W-1:0]         f_sat;
  logic [ACC_W-1:0]         phase_sum;
  logic [PE_W-1:0]          pe_neg;
  logic [PE_W-1:0]          pe_abs;
  logic                     in_bound;
  logic [LOCK_W:0]          cnt_p1;
  logic [NPI-1:0]           pi_base;

  assign upd = lf_if.pe_valid & ~freeze_i & ~en_ext_i;

  // Shift amounts are clamped so a full-scale error never leaves ACC_W bits.
  assign kp_c   = (kp_i > KP_MAX) ? KP_MAX : kp_i;
  assign ki_c   = (ki_i > KI_MAX) ? KI_MAX : ki_i;
  assign pe_sx  = {{(ACC_W-PE_W){lf_if.pe_in[PE_W-1]}}, lf_if.pe_in};
  assign p_term = pe_sx << kp_c;
  assign i_term = pe_sx << ki_c;

  // One guard bit: disagreement between the top two bits means overflow.
  assign f_sum = {freq_q[ACC_W-1], freq_q} + {i_term[ACC_W-1], i_term};
  always_comb begin
    f_sat = f_sum[ACC_W-1:0];
    if (f_sum[ACC_W] != f_sum[ACC_W-1]) begin
      f_sat = f_sum[ACC_W] ? F_MIN : F_MAX;
    end
  end

  assign phase_sum = phase_q + p_term + freq_q;

  always_comb begin
    phase_d = phase_q;
    freq_d  = freq_q;
    if (en_ext_i) begin
      phase_d = {pi_ext_i, {FRAC{1'b0}}};
      freq_d  = '0;
    end else if (upd) begin
      phase_d = phase_sum;
      freq_d  = f_sat;
    end
    if (!en_freq_i) begin
      freq_d = '0;
    end
  end

  // The most negative error magnitude wraps to 2^(PE_W-1), which exceeds any threshold.
  assign pe_neg   = {PE_W{1'b0}} - lf_if.pe_in;
  assign pe_abs   = lf_if.pe_in[PE_W-1] ? pe_neg : lf_if.pe_in;
  assign in_bound = (pe_abs <= {1'b0, lock_thresh_i});
  assign cnt_p1   = {1'b0, cnt_q} + {{LOCK_W{1'b0}}, 1'b1};

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (en_ext_i) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (upd) begin
      if (in_bound) begin
        cnt_d    = cnt_p1[LOCK_W] ? cnt_q : cnt_p1[LOCK_W-1:0];
        locked_d = (cnt_p1 >= {1'b0, lock_len_i});
      end else begin
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    end
    if (lock_len_i == '0) begin
      locked_d = 1'b0;
    end
  end

  assign pi_base = en_ext_i ? pi_ext_i : phase_q[ACC_W-1:FRAC];

  for (genvar k = 0; k < NOUT; k++) begin : g_lane
    assign pi_lane_d[k] = pi_base + pi_offset_i[k];
  end

  always_comb begin
    state_d    = state_q;
    snap_ack   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lf_if.snap_req) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        snap_ack = 1'b1;
        if (!lf_if.snap_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    snap_phase_d = snap_phase_q;
    snap_freq_d  = snap_freq_q;
    if (capture_en) begin
      snap_phase_d = phase_q;
      snap_freq_d  = freq_q;
    end
  end

  always_ff @(posedge clk or negedge ext_rstb) begin
    if (!ext_rstb) begin
      phase_q      <= '0;
      freq_q       <= '0;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      pi_ctl_q     <= '0;
      snap_phase_q <= '0;
      snap_freq_q  <= '0;
      state_q      <= S_IDLE;
    end else begin
      phase_q      <= phase_d;
      freq_q       <= freq_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      snap_phase_q <= snap_phase_d;
      snap_freq_q  <= snap_freq_d;
      state_q      <= state_d;
      for (int k = 0; k < NOUT; k++) begin
        pi_ctl_q[k] <= pi_lane_d[k];
      end
    end
  end

  assign pi_ctl_o         = pi_ctl_q;
  assign locked_o         = locked_q;
  assign lf_if.snap_ack   = snap_ack;
  assign lf_if.snap_phase = snap_phase_q;
  assign lf_if.snap_freq  = snap_freq_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_cdr_loop_filter_mc.sv
`default_nettype none
// ============================================================================
// tb_mm_cdr_loop_filter_mc
// Directed self-checking bench for the PI CDR loop filter.
// Revision: 1.0
// ============================================================================
module tb_mm_cdr_loop_filter_mc;
  localparam int PE_W   = 8;
  localparam int NPI    = 9;
  localparam int NOUT   = 4;
  localparam int FRAC   = 6;
  localparam int KP_W   = 4;
  localparam int KI_W   = 4;
  localparam int LOCK_W = 10;
  localparam int ACC_W  = NPI + FRAC;

  logic                     clk = 1'b0;
  logic                     ext_rstb;
  logic [KP_W-1:0]          kp;
  logic [KI_W-1:0]          ki;
  logic                     en_freq;
  logic                     freeze;
  logic                     en_ext;
  logic [NPI-1:0]           pi_ext;
  logic [NOUT-1:0][NPI-1:0] pi_offset;
  logic [PE_W-2:0]          lock_thresh;
  logic [LOCK_W-1:0]        lock_len;
  logic [NOUT-1:0][NPI-1:0] pi_ctl;
  logic                     locked;

  int checks   = 0;
  int failures = 0;

  mm_cdr_loop_filter_mc_if #(.PE_W(PE_W), .ACC_W(ACC_W)) lf_if ();

  mm_cdr_loop_filter_mc #(
    .PE_W(PE_W), .NPI(NPI), .NOUT(NOUT), .FRAC(FRAC),
    .KP_W(KP_W), .KI_W(KI_W), .LOCK_W(LOCK_W)
  ) dut (
    .clk          (clk),
    .ext_rstb     (ext_rstb),
    .lf_if        (lf_if),
    .kp_i         (kp),
    .ki_i         (ki),
    .en_freq_i    (en_freq),
    .freeze_i     (freeze),
    .en_ext_i     (en_ext),
    .pi_ext_i     (pi_ext),
    .pi_offset_i  (pi_offset),
    .lock_thresh_i(lock_thresh),
    .lock_len_i   (lock_len),
    .pi_ctl_o     (pi_ctl),
    .locked_o     (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [PE_W-1:0] pe);
    lf_if.pe_in    = pe;
    lf_if.pe_valid = 1'b1;
    step();
    lf_if.pe_valid = 1'b0;
  endtask

  task automatic do_snap(output logic [ACC_W-1:0] ph, output logic [ACC_W-1:0] fr);
    lf_if.pe_valid = 1'b0;
    lf_if.snap_req = 1'b1;
    step();
    step();
    ph = lf_if.snap_phase;
    fr = lf_if.snap_freq;
    lf_if.snap_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    ext_rstb       = 1'b0;
    kp             = '0;
    ki             = '0;
    en_freq        = 1'b0;
    freeze         = 1'b0;
    en_ext         = 1'b0;
    pi_ext         = '0;
    pi_offset      = '0;
    lock_thresh    = '0;
    lock_len       = '0;
    lf_if.pe_in    = '0;
    lf_if.pe_valid = 1'b0;
    lf_if.snap_req = 1'b0;
    step();
    step();
    ext_rstb = 1'b1;
    step();
    for (int k = 0; k < NOUT; k++) begin
      checks++;
      if (pi_ctl[k] !== '0) begin
        failures++;
        $display("FAIL reset_pi_ctl[%0d] got=%0d exp=0", k, pi_ctl[k]);
      end
    end
    checks++;
    if (locked !== 1'b0 || lf_if.snap_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags locked=%b ack=%b exp=0/0", locked, lf_if.snap_ack);
    end
    checks++;
    if (lf_if.snap_phase !== '0 || lf_if.snap_freq !== '0) begin
      failures++;
      $display("FAIL reset_snap phase=%0d freq=%0d exp=0/0", lf_if.snap_phase, lf_if.snap_freq);
    end
  endtask

  task automatic test_prop_path();
    logic [ACC_W-1:0] ph, fr;
    kp = 4'd2;
    ki = 4'd0;
    en_freq = 1'b0;
    sample(8'sd3);
    do_snap(ph, fr);
    checks++;
    if (ph !== 15'd12 || fr !== 15'd0) begin
      failures++;
      $display("FAIL prop_first phase=%0d freq=%0d exp=12/0", ph, fr);
    end
    checks++;
    if (pi_ctl[0] !== 9'd0) begin
      failures++;
      $display("FAIL prop_first_pi got=%0d exp=0", pi_ctl[0]);
    end
    for (int s = 0; s < 16; s++) sample(8'sd8);
    // phase now 524; pi_ctl still reflects 492 until the next edge
    checks++;
    if (pi_ctl[0] !== 9'd7) begin
      failures++;
      $display("FAIL prop_latency got=%0d exp=7", pi_ctl[0]);
    end
    step();
    for (int k = 0; k < NOUT; k++) begin
      checks++;
      if (pi_ctl[k] !== 9'd8) begin
        failures++;
        $display("FAIL prop_16x8[%0d] got=%0d exp=8", k, pi_ctl[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ACC_W-1:0] ph, fr;
    pi_ext = 9'd511;
    en_ext = 1'b1;
    step();
    for (int k = 0; k < NOUT; k++) begin
      checks++;
      if (pi_ctl[k] !== 9'd511) begin
        failures++;
        $display("FAIL ext_511[%0d] got=%0d exp=511", k, pi_ctl[k]);
      end
    end
    en_ext = 1'b0;
    kp = 4'd2;
    sample(8'sd16);
    step();
    for (int k = 0; k < NOUT; k++) begin
      checks++;
      if (pi_ctl[k] !== 9'd0) begin
        failures++;
        $display("FAIL wrap[%0d] got=%0d exp=0", k, pi_ctl[k]);
      end
    end
    do_snap(ph, fr);
    checks++;
    if (ph !== 15'd0) begin
      failures++;
      $display("FAIL wrap_phase got=%0d exp=0", ph);
    end
    pi_ext = 9'd510;
    pi_offset[3] = 9'd5;
    en_ext = 1'b1;
    step();
    checks++;
    if (pi_ctl[3] !== 9'd3 || pi_ctl[0] !== 9'd510) begin
      failures++;
      $display("FAIL offset_wrap lane3=%0d lane0=%0d exp=3/510", pi_ctl[3], pi_ctl[0]);
    end
    en_ext = 1'b0;
  endtask

  task automatic test_freq_sat();
    logic [ACC_W-1:0] ph, fr;
    kp = 4'd0;
    ki = 4'hF;
    en_freq = 1'b1;
    sample(8'sd127);
    do_snap(ph, fr);
    checks++;
    if (fr !== 15'd16256) begin
      failures++;
      $display("FAIL freq_one got=%0d exp=16256", fr);
    end
    for (int s = 0; s < 3; s++) sample(8'sd127);
    do_snap(ph, fr);
    checks++;
    if (fr !== 15'h3FFF) begin
      failures++;
      $display("FAIL freq_sat_pos got=%h exp=3fff", fr);
    end
    sample(-8'sd128);
    do_snap(ph, fr);
    checks++;
    if (fr !== 15'h7FFF) begin
      failures++;
      $display("FAIL freq_minus1 got=%h exp=7fff", fr);
    end
    sample(-8'sd128);
    sample(-8'sd128);
    do_snap(ph, fr);
    checks++;
    if (fr !== 15'h4000) begin
      failures++;
      $display("FAIL freq_sat_neg got=%h exp=4000", fr);
    end
    en_freq = 1'b0;
    do_snap(ph, fr);
    checks++;
    if (fr !== 15'd0) begin
      failures++;
      $display("FAIL freq_clear got=%h exp=0", fr);
    end
  endtask

  task automatic test_lock();
    logic signed [PE_W-1:0] in_b [8];
    in_b = '{8'sd4, -8'sd4, 8'sd0, 8'sd3, -8'sd1, 8'sd2, -8'sd3, 8'sd1};
    en_freq = 1'b0;
    kp = 4'd0;
    lock_thresh = 7'd4;
    lock_len = 10'd8;
    sample(8'sd100);
    for (int s = 0; s < 7; s++) sample(in_b[s]);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_7 got=%b exp=0", locked);
    end
    sample(in_b[7]);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_8 got=%b exp=1", locked);
    end
    sample(-8'sd5);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_drop_m5 got=%b exp=0", locked);
    end
    for (int s = 0; s < 8; s++) sample(8'sd0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL relock got=%b exp=1", locked);
    end
    sample(-8'sd128);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_m128 got=%b exp=0", locked);
    end
    lock_len = 10'd0;
    for (int s = 0; s < 10; s++) sample(8'sd0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_len0 got=%b exp=0", locked);
    end
    lock_len = 10'd8;
    for (int s = 0; s < 8; s++) sample(8'sd0);
    en_ext = 1'b1;
    step();
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_ext_clear got=%b exp=0", locked);
    end
    en_ext = 1'b0;
  endtask

  task automatic test_freeze();
    logic [ACC_W-1:0] ph, fr;
    kp = 4'd2;
    ki = 4'd0;
    en_freq = 1'b1;
    lock_thresh = 7'd4;
    lock_len = 10'd8;
    pi_ext = 9'd100;
    en_ext = 1'b1;
    step();
    en_ext = 1'b0;
    for (int s = 0; s < 7; s++) sample(8'sd0);
    freeze = 1'b1;
    lf_if.pe_in = 8'sd50;
    lf_if.pe_valid = 1'b1;
    for (int s = 0; s < 10; s++) step();
    freeze = 1'b0;
    lf_if.pe_valid = 1'b0;
    checks++;
    if (pi_ctl[0] !== 9'd100 || pi_ctl[3] !== 9'd105 || locked !== 1'b0) begin
      failures++;
      $display("FAIL freeze lane0=%0d lane3=%0d locked=%b exp=100/105/0", pi_ctl[0], pi_ctl[3], locked);
    end
    for (int s = 0; s < 5; s++) step();
    checks++;
    if (pi_ctl[0] !== 9'd100 || locked !== 1'b0) begin
      failures++;
      $display("FAIL invalid_hold lane0=%0d locked=%b exp=100/0", pi_ctl[0], locked);
    end
    do_snap(ph, fr);
    checks++;
    if (ph !== 15'd6400 || fr !== 15'd0) begin
      failures++;
      $display("FAIL freeze_accs phase=%0d freq=%0d exp=6400/0", ph, fr);
    end
    sample(8'sd0);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_cnt_kept got=%b exp=1", locked);
    end
  endtask

  task automatic test_snapshot();
    en_freq = 1'b0;
    kp = 4'd2;
    lf_if.snap_req = 1'b1;
    lf_if.pe_in = 8'sd8;
    lf_if.pe_valid = 1'b1;
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b0) begin
      failures++;
      $display("FAIL snap_e1_ack got=%b exp=0", lf_if.snap_ack);
    end
    lf_if.pe_in = -8'sd8;
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b1 || lf_if.snap_phase !== 15'd6432) begin
      failures++;
      $display("FAIL snap_e2 ack=%b phase=%0d exp=1/6432", lf_if.snap_ack, lf_if.snap_phase);
    end
    lf_if.pe_in = 8'sd20;
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b1 || lf_if.snap_phase !== 15'd6432 || lf_if.snap_freq !== 15'd0) begin
      failures++;
      $display("FAIL snap_stable ack=%b phase=%0d freq=%0d exp=1/6432/0",
               lf_if.snap_ack, lf_if.snap_phase, lf_if.snap_freq);
    end
    lf_if.snap_req = 1'b0;
    lf_if.pe_in = 8'sd8;
    step();
    lf_if.pe_valid = 1'b0;
    checks++;
    if (lf_if.snap_ack !== 1'b0) begin
      failures++;
      $display("FAIL snap_ack_fall got=%b exp=0", lf_if.snap_ack);
    end
    lf_if.snap_req = 1'b1;
    step();
    lf_if.snap_req = 1'b0;
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b1 || lf_if.snap_phase !== 15'd6512) begin
      failures++;
      $display("FAIL snap_short ack=%b phase=%0d exp=1/6512", lf_if.snap_ack, lf_if.snap_phase);
    end
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b0) begin
      failures++;
      $display("FAIL snap_short_end got=%b exp=0", lf_if.snap_ack);
    end
    lf_if.snap_req = 1'b1;
    step();
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b1) begin
      failures++;
      $display("FAIL snap_pre_reset got=%b exp=1", lf_if.snap_ack);
    end
    #2;
    ext_rstb = 1'b0;
    #1;
    checks++;
    if (lf_if.snap_ack !== 1'b0 || lf_if.snap_phase !== '0 || pi_ctl[3] !== '0) begin
      failures++;
      $display("FAIL async_reset ack=%b phase=%0d pi3=%0d exp=0/0/0",
               lf_if.snap_ack, lf_if.snap_phase, pi_ctl[3]);
    end
    ext_rstb = 1'b1;
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_capture got=%b exp=0", lf_if.snap_ack);
    end
    step();
    checks++;
    if (lf_if.snap_ack !== 1'b1 || lf_if.snap_phase !== '0) begin
      failures++;
      $display("FAIL post_reset_hold ack=%b phase=%0d exp=1/0", lf_if.snap_ack, lf_if.snap_phase);
    end
    lf_if.snap_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_prop_path();
    test_wrap();
    test_freq_sat();
    test_lock();
    test_freeze();
    test_snapshot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
